// File: rtl/interrupt_sequencer_pkg.sv
// interrupt_sequencer_pkg
//   Shared types and constants for the interrupt entry/exit sequencer:
//   sequencer state encoding, the bundle of per-state control strobes and
//   the helper that maps a state onto those strobes.
package interrupt_sequencer_pkg;

  localparam int          INTSEQ_DATA_W = 16;
  localparam logic [15:0] INT_VEC_ADDR  = 16'h0001;

  typedef enum logic [2:0] {
    INTSEQ_IDLE   = 3'd0,
    INTSEQ_WAIT   = 3'd1,  // request pending, waiting for an instruction boundary
    INTSEQ_PUSHPC = 3'd2,
    INTSEQ_PUSHF  = 3'd3,
    INTSEQ_VECRD  = 3'd4,
    INTSEQ_VECLD  = 3'd5,
    INTSEQ_ISR    = 3'd6,
    INTSEQ_POPF   = 3'd7
  } intseq_state_e;

  // Control strobes seen by the datapath / control unit.
  typedef struct packed {
    logic hw_int;
    logic push_flags;
    logic pop_flags;
    logic vec_read;
    logic pc_load;
    logic stall_fetch;
    logic in_service;
  } intseq_ctl_t;

  // Moore decode: which strobes are active while sitting in state s.
  function automatic intseq_ctl_t intseq_decode(input intseq_state_e s);
    intseq_ctl_t c;
    c = 7'b000_0000;
    case (s)
      INTSEQ_PUSHPC: begin
        c.hw_int      = 1'b1;
        c.stall_fetch = 1'b1;
      end
      INTSEQ_PUSHF: begin
        c.push_flags  = 1'b1;
        c.stall_fetch = 1'b1;
      end
      INTSEQ_VECRD: begin
        c.vec_read    = 1'b1;
        c.stall_fetch = 1'b1;
      end
      INTSEQ_VECLD: begin
        c.pc_load     = 1'b1;
        c.stall_fetch = 1'b1;
        c.in_service  = 1'b1;
      end
      INTSEQ_ISR: begin
        c.in_service  = 1'b1;
      end
      INTSEQ_POPF: begin
        c.pop_flags   = 1'b1;
        c.stall_fetch = 1'b1;
        c.in_service  = 1'b1;
      end
      default: begin
        c = 7'b000_0000;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// interrupt_sequencer_if
//   Bundles the sequencer's pin/pipeline inputs and its control outputs.
//   master : the surrounding CPU/pad logic (drives requests, reads strobes)
//   slave  : the interrupt sequencer itself
//   Inputs to sequencer : int_pin, inst_boundary, rti_retire, vec_data
//   Outputs             : is_hardware_int, push_flags, pop_flags, vec_read,
//                         vec_addr, pc_load, pc_load_value, stall_fetch,
//                         in_service
interface interrupt_sequencer_if
  import interrupt_sequencer_pkg::*;
#(
  parameter int DATA_W = INTSEQ_DATA_W
);
  logic              int_pin;
  logic              inst_boundary;
  logic              rti_retire;
  logic [DATA_W-1:0] vec_data;

  logic              is_hardware_int;
  logic              push_flags;
  logic              pop_flags;
  logic              vec_read;
  logic [DATA_W-1:0] vec_addr;
  logic              pc_load;
  logic [DATA_W-1:0] pc_load_value;
  logic              stall_fetch;
  logic              in_service;

  modport master (
    output int_pin, inst_boundary, rti_retire, vec_data,
    input  is_hardware_int, push_flags, pop_flags, vec_read, vec_addr,
           pc_load, pc_load_value, stall_fetch, in_service
  );

  modport slave (
    input  int_pin, inst_boundary, rti_retire, vec_data,
    output is_hardware_int, push_flags, pop_flags, vec_read, vec_addr,
           pc_load, pc_load_value, stall_fetch, in_service
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer
//   Turns a rising edge on the interrupt pin into the interrupt entry
//   sequence (PC push, flags push, vector read, PC load), then holds off
//   further interrupts until RTI retires and the flags are popped.
//   Ports:
//     clk  - system clock, rising-edge
//     rst  - asynchronous active-high reset, aborts any sequence in flight
//     bus  - interrupt_sequencer_if.slave (requests in, control strobes out)
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int              DATA_W   = INTSEQ_DATA_W,
  parameter logic [DATA_W-1:0] VEC_ADDR = DATA_W'(INT_VEC_ADDR)
) (
  input  logic                  clk,
  input  logic                  rst,
  interrupt_sequencer_if.slave  bus
);

  intseq_state_e     state_q, state_d;
  logic              int_q;
  logic              pending_q, pending_d;
  intseq_ctl_t       ctl_q, ctl_d;
  logic [DATA_W-1:0] vec_addr_q, vec_addr_d;
  logic [DATA_W-1:0] isr_addr_q, isr_addr_d;
  logic              rise_s;
  logic              take_s;

  assign rise_s = bus.int_pin & ~int_q;
  // A request is consumed the moment the sequencer commits to the PC push.
  assign take_s = (state_q == INTSEQ_WAIT) & bus.inst_boundary;

  // Next-state, pending-request and output-register input logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INTSEQ_IDLE: begin
        if (pending_q) state_d = INTSEQ_WAIT;
        else           state_d = INTSEQ_IDLE;
      end
      INTSEQ_WAIT: begin
        if (bus.inst_boundary) state_d = INTSEQ_PUSHPC;
        else                   state_d = INTSEQ_WAIT;
      end
      INTSEQ_PUSHPC: state_d = INTSEQ_PUSHF;
      INTSEQ_PUSHF:  state_d = INTSEQ_VECRD;
      INTSEQ_VECRD:  state_d = INTSEQ_VECLD;
      INTSEQ_VECLD:  state_d = INTSEQ_ISR;
      INTSEQ_ISR: begin
        // rti_retire only matters here; elsewhere it is ignored.
        if (bus.rti_retire) state_d = INTSEQ_POPF;
        else                state_d = INTSEQ_ISR;
      end
      INTSEQ_POPF:   state_d = INTSEQ_IDLE;
      default:       state_d = INTSEQ_IDLE;
    endcase

    // Clearing on take wins over a coincident edge: that edge is absorbed
    // into the request being serviced. Only one request is ever queued.
    pending_d = pending_q;
    if (take_s)      pending_d = 1'b0;
    else if (rise_s) pending_d = 1'b1;
    else             pending_d = pending_q;

    // Strobes are decoded from the next state and registered, so they line
    // up exactly with the state register without a combinational path.
    ctl_d = intseq_decode(state_d);

    vec_addr_d = {DATA_W{1'b0}};
    if (ctl_d.vec_read) vec_addr_d = VEC_ADDR;
    else                vec_addr_d = {DATA_W{1'b0}};

    // vec_data is valid during VEC_LD only (1-cycle read latency).
    isr_addr_d = isr_addr_q;
    if (state_q == INTSEQ_VECLD) isr_addr_d = bus.vec_data;
    else                         isr_addr_d = isr_addr_q;
  end

  // Edge detector, sequencer state and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INTSEQ_IDLE;
      int_q      <= 1'b0;
      pending_q  <= 1'b0;
      ctl_q      <= 7'b000_0000;
      vec_addr_q <= {DATA_W{1'b0}};
      isr_addr_q <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      int_q      <= bus.int_pin;
      pending_q  <= pending_d;
      ctl_q      <= ctl_d;
      vec_addr_q <= vec_addr_d;
      isr_addr_q <= isr_addr_d;
    end
  end

  assign bus.is_hardware_int = ctl_q.hw_int;
  assign bus.push_flags      = ctl_q.push_flags;
  assign bus.pop_flags       = ctl_q.pop_flags;
  assign bus.vec_read        = ctl_q.vec_read;
  assign bus.vec_addr        = vec_addr_q;
  assign bus.pc_load         = ctl_q.pc_load;
  assign bus.stall_fetch     = ctl_q.stall_fetch;
  assign bus.in_service      = ctl_q.in_service;
  // The PC loads at the end of VEC_LD, so the read data must be presented
  // in that same cycle; afterwards the captured copy is held.
  assign bus.pc_load_value   = (state_q == INTSEQ_VECLD) ? bus.vec_data : isr_addr_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer
//   Directed, table-driven bench for interrupt_sequencer. Each table row
//   gives the inputs present at a rising clock edge and the outputs expected
//   just after that edge. Reset behaviour is exercised by hand.
module tb_interrupt_sequencer;

  // Flag order: {is_hardware_int, push_flags, pop_flags, vec_read, pc_load,
  //              stall_fetch, in_service}
  localparam logic [6:0] F0   = 7'b000_0000;
  localparam logic [6:0] F_PC = 7'b100_0010;
  localparam logic [6:0] F_PF = 7'b010_0010;
  localparam logic [6:0] F_VR = 7'b000_1010;
  localparam logic [6:0] F_VL = 7'b000_0111;
  localparam logic [6:0] F_IS = 7'b000_0001;
  localparam logic [6:0] F_PO = 7'b001_0011;
  localparam logic [15:0] VA  = 16'h0001;
  localparam logic [15:0] Z16 = 16'h0000;

  typedef struct {
    logic        ip;
    logic        ib;
    logic        rti;
    logic [15:0] vd;
    logic [6:0]  ef;
    logic [15:0] ea;
    logic [15:0] epv;
  } row_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  row_t rows[$];

  interrupt_sequencer_if #(.DATA_W(16)) bus ();

  interrupt_sequencer #(.DATA_W(16), .VEC_ADDR(16'h0001)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic ip, input logic ib, input logic rti,
                              input logic [15:0] vd, input logic [6:0] ef,
                              input logic [15:0] ea, input logic [15:0] epv);
    row_t r;
    r.ip = ip; r.ib = ib; r.rti = rti; r.vd = vd;
    r.ef = ef; r.ea = ea; r.epv = epv;
    rows.push_back(r);
  endfunction

  task automatic check(input string name, input logic [6:0] ef,
                       input logic [15:0] ea, input logic [15:0] epv,
                       input bit chk_pv);
    logic [6:0] af;
    af = {bus.is_hardware_int, bus.push_flags, bus.pop_flags, bus.vec_read,
          bus.pc_load, bus.stall_fetch, bus.in_service};
    checks++;
    if (af !== ef || bus.vec_addr !== ea || (chk_pv && bus.pc_load_value !== epv)) begin
      errors++;
      $display("FAIL %s: got flags=%b vec_addr=%h pc_load_value=%h, want flags=%b vec_addr=%h pc_load_value=%h",
               name, af, bus.vec_addr, bus.pc_load_value, ef, ea, epv);
    end
  endtask

  task automatic drive(input logic ip, input logic ib, input logic rti,
                       input logic [15:0] vd);
    bus.int_pin       = ip;
    bus.inst_boundary = ib;
    bus.rti_retire    = rti;
    bus.vec_data      = vd;
  endtask

  initial begin
    // Basic entry, int_pin then held high for 20 cycles: one sequence only.
    add(1'b1,1'b1,1'b0,16'h0200,F0,  Z16,Z16);   // edge -> pending
    add(1'b1,1'b1,1'b0,16'h0200,F0,  Z16,Z16);   // WAIT_BND
    add(1'b1,1'b1,1'b0,16'h0200,F_PC,Z16,Z16);   // +2
    add(1'b1,1'b1,1'b0,16'h0200,F_PF,Z16,Z16);   // +3
    add(1'b1,1'b1,1'b0,16'h0200,F_VR,VA, Z16);   // +4
    add(1'b1,1'b1,1'b0,16'h0200,F_VL,Z16,16'h0200); // +5
    for (int i = 0; i < 3; i++) add(1'b1,1'b1,1'b0,16'h0200,F_IS,Z16,Z16);
    add(1'b1,1'b1,1'b1,16'h0200,F_PO,Z16,Z16);   // RTI retires
    for (int i = 0; i < 10; i++) add(1'b1,1'b1,1'b0,16'h0200,F0,Z16,Z16);
    add(1'b0,1'b1,1'b0,16'h0200,F0,Z16,Z16);
    // rti_retire while idle is ignored.
    add(1'b0,1'b1,1'b1,16'h0200,F0,Z16,Z16);
    add(1'b0,1'b1,1'b1,16'h0200,F0,Z16,Z16);
    // Boundary wait (4+ cycles) with a second edge absorbed while pending.
    add(1'b1,1'b0,1'b0,16'h1234,F0,Z16,Z16);     // edge
    add(1'b1,1'b0,1'b0,16'h1234,F0,Z16,Z16);     // WAIT_BND
    add(1'b0,1'b0,1'b0,16'h1234,F0,Z16,Z16);
    add(1'b1,1'b0,1'b1,16'h1234,F0,Z16,Z16);     // 2nd edge, stray rti
    add(1'b1,1'b0,1'b0,16'h1234,F0,Z16,Z16);
    add(1'b1,1'b0,1'b0,16'h1234,F0,Z16,Z16);
    add(1'b1,1'b1,1'b0,16'h1234,F_PC,Z16,Z16);
    add(1'b1,1'b1,1'b0,16'h1234,F_PF,Z16,Z16);
    add(1'b1,1'b1,1'b0,16'h1234,F_VR,VA, Z16);
    add(1'b1,1'b1,1'b0,16'h1234,F_VL,Z16,16'h1234);
    add(1'b1,1'b1,1'b0,16'h1234,F_IS,Z16,Z16);
    add(1'b1,1'b1,1'b1,16'h1234,F_PO,Z16,Z16);
    for (int i = 0; i < 4; i++) add(1'b1,1'b1,1'b0,16'h1234,F0,Z16,Z16);
    add(1'b0,1'b1,1'b0,16'h1234,F0,Z16,Z16);
    // Nesting: edge during ISR is deferred until after the flags pop.
    add(1'b1,1'b1,1'b0,16'hBEEF,F0,  Z16,Z16);
    add(1'b1,1'b1,1'b0,16'hBEEF,F0,  Z16,Z16);
    add(1'b1,1'b1,1'b0,16'hBEEF,F_PC,Z16,Z16);
    add(1'b1,1'b1,1'b0,16'hBEEF,F_PF,Z16,Z16);
    add(1'b1,1'b1,1'b0,16'hBEEF,F_VR,VA, Z16);
    add(1'b1,1'b1,1'b0,16'hBEEF,F_VL,Z16,16'hBEEF);
    add(1'b0,1'b1,1'b0,16'hBEEF,F_IS,Z16,Z16);
    add(1'b1,1'b1,1'b0,16'hBEEF,F_IS,Z16,Z16);   // edge while in service
    add(1'b1,1'b1,1'b0,16'hBEEF,F_IS,Z16,Z16);
    add(1'b1,1'b1,1'b1,16'hBEEF,F_PO,Z16,Z16);   // m
    add(1'b1,1'b1,1'b0,16'h0F0F,F0,  Z16,Z16);   // IDLE
    add(1'b1,1'b1,1'b0,16'h0F0F,F0,  Z16,Z16);   // WAIT_BND
    add(1'b1,1'b1,1'b0,16'h0F0F,F_PC,Z16,Z16);
    add(1'b1,1'b1,1'b0,16'h0F0F,F_PF,Z16,Z16);
    add(1'b1,1'b1,1'b0,16'h0F0F,F_VR,VA, Z16);
    add(1'b1,1'b1,1'b0,16'h0F0F,F_VL,Z16,16'h0F0F);
    add(1'b1,1'b1,1'b0,16'h0F0F,F_IS,Z16,Z16);
    add(1'b1,1'b1,1'b1,16'h0F0F,F_PO,Z16,Z16);
    add(1'b0,1'b1,1'b0,16'h0F0F,F0,  Z16,Z16);
    add(1'b0,1'b1,1'b0,16'h0F0F,F0,  Z16,Z16);

    // Reset state.
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1 check("reset", F0, Z16, Z16, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk);
      drive(rows[i].ip, rows[i].ib, rows[i].rti, rows[i].vd);
      @(posedge clk);
      #1 check($sformatf("row%0d", i), rows[i].ef, rows[i].ea, rows[i].epv, rows[i].ef[2]);
    end

    // Reset asserted mid-VEC_RD aborts at once; nothing follows.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 16'h5A5A);
    repeat (2) @(posedge clk);                   // pending, WAIT_BND
    repeat (3) @(posedge clk);                   // PUSH_PC, PUSH_FLG, VEC_RD
    #1 check("pre_rst_vecrd", F_VR, VA, Z16, 1'b0);
    #2 rst = 1'b1;
    #1 check("rst_mid_vecrd", F0, Z16, Z16, 1'b1);
    @(negedge clk);
    bus.int_pin = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 check($sformatf("post_rst%0d", i), F0, Z16, Z16, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
